// File: rtl/rll_key_pkg.sv
// rll_key_pkg: shared FSM state type, default key width and key parity helper for the RLL key loader.
// RLL_KEY_PARITY_EN adds the PARITY state to the enum.
package rll_key_pkg;
  localparam int KEY_W_DEFAULT = 16;
`ifdef RLL_KEY_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, APPLY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, APPLY} state_t;
`endif
  // Zero-extension leaves parity unchanged, so any key width up to 64 fits.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/rll16_key_loader.sv
// rll16_key_loader: serial LSB-first key loader for a locked netlist, with atomic key_out update.
// Define RLL_KEY_PARITY_EN to require a trailing even-parity bit; otherwise key_err stays 0.
module rll16_key_loader
  import rll_key_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             key_bit,
  input  logic             key_valid,
  input  logic             key_clear,
  output logic [KEY_W-1:0] key_out,
  output logic             key_ready,
  output logic             busy,
  output logic             key_err
);
  localparam int CW = $clog2(KEY_W + 1);
`ifdef RLL_KEY_PARITY_EN
  localparam state_t AFTER_SHIFT = PARITY;
`else
  localparam state_t AFTER_SHIFT = APPLY;
`endif
  state_t           r_state, w_state;
  logic [CW-1:0]    r_count, w_count;
  logic [KEY_W-1:0] r_shadow, w_shadow, r_key, w_key;
  logic             r_ready, w_ready, r_err, w_err;
  logic             w_last;
  assign w_last    = r_count == CW'(KEY_W - 1);
  assign key_out   = r_key;
  assign key_ready = r_ready;
  assign key_err   = r_err;
  assign busy      = r_state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_shadow <= '0;
      r_key    <= '0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_count  <= w_count;
      r_shadow <= w_shadow;
      r_key    <= w_key;
      r_ready  <= w_ready;
      r_err    <= w_err;
    end
  end
  always_comb begin
    w_state  = r_state;
    w_count  = r_count;
    w_shadow = r_shadow;
    w_key    = r_key;
    w_ready  = r_ready;
    w_err    = r_err;
    if (key_clear) begin
      w_state  = IDLE;
      w_count  = '0;
      w_shadow = '0;
      w_key    = '0;
      w_ready  = 1'b0;
      w_err    = 1'b0;
    end else begin
      case (r_state)
        IDLE: if (load_start) begin
          w_state  = SHIFT;
          w_count  = '0;
          w_shadow = '0;
          w_ready  = 1'b0;
          w_err    = 1'b0;
        end
        SHIFT: if (load_start) begin
          w_count  = '0;
          w_shadow = '0;
        end else if (key_valid) begin
          // Shadow bits are zeroed at load start, so OR-ing in each bit writes it.
          w_shadow = r_shadow | (KEY_W'(key_bit) << r_count);
          w_count  = r_count + 1'b1;
          w_state  = w_last ? AFTER_SHIFT : SHIFT;
        end
`ifdef RLL_KEY_PARITY_EN
        PARITY: if (load_start) begin
          w_state  = SHIFT;
          w_count  = '0;
          w_shadow = '0;
        end else if (key_valid) begin
          w_state = IDLE;
          if (key_bit == even_parity(64'(r_shadow))) w_state = APPLY;
          else w_err = 1'b1;
        end
`endif
        APPLY: begin
          w_key   = r_shadow;
          w_ready = 1'b1;
          w_state = IDLE;
        end
        default: w_state = IDLE;
      endcase
    end
  end
endmodule
